// File: rtl/pong_duel.sv
// pong_duel: two-player Pong engine for the VGA pixel pipeline.
// Game state (paddles, ball, scores, serve/play/point/game-over FSM) advances
// only on frame_tick; pixel is a registered object mask with 1-cycle latency.
// Build option: define PONG_AI_EN to have the right paddle track the ball
// automatically (btn_r_up/btn_r_dn are then ignored).
module pong_duel #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int PADDLE_H     = 48,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_X     = 16,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               btn_l_up,
    input  logic               btn_l_dn,
    input  logic               btn_r_up,
    input  logic               btn_r_dn,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    output logic               pixel,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over
);

    // One extra bit so that stepping past 0 goes negative instead of wrapping.
    typedef logic signed [X_W:0] sx_t;
    typedef logic signed [Y_W:0] sy_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam sx_t X_ZERO     = '0;
    localparam sx_t BALL_X0    = sx_t'((SCREEN_W - BALL_SIZE) / 2);
    localparam sx_t BALL_X_MAX = sx_t'(SCREEN_W - BALL_SIZE);
    localparam sx_t BSZ_X      = sx_t'(BALL_SIZE);
    localparam sx_t BSPD_X     = sx_t'(BALL_SPEED);
    localparam sx_t LPX        = sx_t'(PADDLE_X);
    localparam sx_t RPX        = sx_t'(SCREEN_W - PADDLE_X - PADDLE_W);
    localparam sx_t PW_X       = sx_t'(PADDLE_W);
    localparam sx_t NET_X      = sx_t'(SCREEN_W / 2);

    localparam sy_t Y_ZERO     = '0;
    localparam sy_t BALL_Y0    = sy_t'((SCREEN_H - BALL_SIZE) / 2);
    localparam sy_t BALL_Y_MAX = sy_t'(SCREEN_H - BALL_SIZE);
    localparam sy_t BSZ_Y      = sy_t'(BALL_SIZE);
    localparam sy_t BSPD_Y     = sy_t'(BALL_SPEED);
    localparam sy_t PAD_Y0     = sy_t'((SCREEN_H - PADDLE_H) / 2);
    localparam sy_t PAD_Y_MAX  = sy_t'(SCREEN_H - PADDLE_H);
    localparam sy_t PH_Y       = sy_t'(PADDLE_H);
    localparam sy_t PSPD_Y     = sy_t'(PADDLE_SPEED);

    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_POINT, ST_GAMEOVER} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   serve_cnt_reg, serve_cnt_next;
    logic [X_W-1:0]     ball_x_reg, ball_x_next;
    logic [Y_W-1:0]     ball_y_reg, ball_y_next;
    logic               dx_pos_reg, dx_pos_next;
    logic               dy_pos_reg, dy_pos_next;
    logic [Y_W-1:0]     pad_l_reg, pad_l_next;
    logic [Y_W-1:0]     pad_r_reg, pad_r_next;
    logic [SCORE_W-1:0] score_l_reg, score_l_next;
    logic [SCORE_W-1:0] score_r_reg, score_r_next;
    logic               left_scored_reg, left_scored_next;
    logic               pixel_reg, pixel_next;

    sx_t bx_s, nx, xs;
    sy_t by_s, ny, ys, pl_s, pr_s, pl_move, pr_move;
    logic hit_l, hit_r;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;
    logic pix_ball, pix_l, pix_r, pix_net;

    assign bx_s = $signed({1'b0, ball_x_reg});
    assign by_s = $signed({1'b0, ball_y_reg});
    assign pl_s = $signed({1'b0, pad_l_reg});
    assign pr_s = $signed({1'b0, pad_r_reg});

    function automatic logic [Y_W-1:0] clamp_pad(input sy_t v);
        sy_t c;
        c = v;
        if (v < Y_ZERO)
            c = Y_ZERO;
        else if (v > PAD_Y_MAX)
            c = PAD_Y_MAX;
        return c[Y_W-1:0];
    endfunction

`ifdef PONG_AI_EN
    sy_t ai_err;
    logic unused_btn_r;
    assign unused_btn_r = btn_r_up ^ btn_r_dn;
`endif

    // Unclamped paddle candidates for this frame: button step or ball tracking.
    always_comb begin
        pl_move = pl_s;
        if (btn_l_up && !btn_l_dn)
            pl_move = pl_s - PSPD_Y;
        else if (btn_l_dn && !btn_l_up)
            pl_move = pl_s + PSPD_Y;
        pr_move = pr_s;
`ifdef PONG_AI_EN
        // Steer the paddle centre toward the ball centre; dead band avoids jitter.
        ai_err = (by_s + (BSZ_Y >>> 1)) - (pr_s + (PH_Y >>> 1));
        if (ai_err >= PSPD_Y)
            pr_move = pr_s + PSPD_Y;
        else if (ai_err <= -PSPD_Y)
            pr_move = pr_s - PSPD_Y;
`else
        if (btn_r_up && !btn_r_dn)
            pr_move = pr_s - PSPD_Y;
        else if (btn_r_dn && !btn_r_up)
            pr_move = pr_s + PSPD_Y;
`endif
    end

    // Per-frame game update: FSM, ball motion with bounces, scoring.
    always_comb begin
        state_next       = state_reg;
        serve_cnt_next   = serve_cnt_reg;
        ball_x_next      = ball_x_reg;
        ball_y_next      = ball_y_reg;
        dx_pos_next      = dx_pos_reg;
        dy_pos_next      = dy_pos_reg;
        pad_l_next       = pad_l_reg;
        pad_r_next       = pad_r_reg;
        score_l_next     = score_l_reg;
        score_r_next     = score_r_reg;
        left_scored_next = left_scored_reg;
        nx               = bx_s + (dx_pos_reg ? BSPD_X : -BSPD_X);
        ny               = by_s + (dy_pos_reg ? BSPD_Y : -BSPD_Y);
        hit_l            = 1'b0;
        hit_r            = 1'b0;
        score_l_inc      = score_l_reg + 1'b1;
        score_r_inc      = score_r_reg + 1'b1;
        if (frame_tick) begin
            if (state_reg != ST_GAMEOVER) begin
                pad_l_next = clamp_pad(pl_move);
                pad_r_next = clamp_pad(pr_move);
            end
            case (state_reg)
                ST_SERVE: begin
                    if (serve_cnt_reg == SERVE_LAST) begin
                        state_next     = ST_PLAY;
                        serve_cnt_next = '0;
                    end else begin
                        serve_cnt_next = serve_cnt_reg + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (ny <= Y_ZERO) begin
                        ny          = Y_ZERO;
                        dy_pos_next = 1'b1;
                    end else if (ny >= BALL_Y_MAX) begin
                        ny          = BALL_Y_MAX;
                        dy_pos_next = 1'b0;
                    end
                    // Collisions use the paddle positions from before this frame's move.
                    hit_l = !dx_pos_reg && (nx <= LPX + PW_X) && (nx + BSZ_X > LPX) &&
                            (ny + BSZ_Y > pl_s) && (ny < pl_s + PH_Y);
                    hit_r = dx_pos_reg && (nx + BSZ_X >= RPX) && (nx < RPX + PW_X) &&
                            (ny + BSZ_Y > pr_s) && (ny < pr_s + PH_Y);
                    if (hit_l) begin
                        nx          = LPX + PW_X;
                        dx_pos_next = 1'b1;
                    end else if (hit_r) begin
                        nx          = RPX - BSZ_X;
                        dx_pos_next = 1'b0;
                    end
                    ball_x_next = nx[X_W-1:0];
                    ball_y_next = ny[Y_W-1:0];
                    if (nx <= X_ZERO) begin
                        state_next       = ST_POINT;
                        left_scored_next = 1'b0;
                    end else if (nx >= BALL_X_MAX) begin
                        state_next       = ST_POINT;
                        left_scored_next = 1'b1;
                    end
                end
                ST_POINT: begin
                    serve_cnt_next = '0;
                    if (left_scored_reg) begin
                        if (score_l_reg < WIN_S)
                            score_l_next = score_l_inc;
                    end else begin
                        if (score_r_reg < WIN_S)
                            score_r_next = score_r_inc;
                    end
                    if ((left_scored_reg ? score_l_inc : score_r_inc) == WIN_S) begin
                        state_next = ST_GAMEOVER;
                    end else begin
                        // Re-serve from the centre, heading toward the player who conceded.
                        state_next  = ST_SERVE;
                        ball_x_next = BALL_X0[X_W-1:0];
                        ball_y_next = BALL_Y0[Y_W-1:0];
                        dx_pos_next = left_scored_reg;
                        dy_pos_next = 1'b1;
                    end
                end
                ST_GAMEOVER: begin
                    if (start) begin
                        state_next     = ST_SERVE;
                        serve_cnt_next = '0;
                        score_l_next   = '0;
                        score_r_next   = '0;
                        ball_x_next    = BALL_X0[X_W-1:0];
                        ball_y_next    = BALL_Y0[Y_W-1:0];
                        dx_pos_next    = 1'b1;
                        dy_pos_next    = 1'b1;
                        pad_l_next     = PAD_Y0[Y_W-1:0];
                        pad_r_next     = PAD_Y0[Y_W-1:0];
                    end
                end
            endcase
        end
    end

    // Game state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_SERVE;
            serve_cnt_reg   <= '0;
            ball_x_reg      <= BALL_X0[X_W-1:0];
            ball_y_reg      <= BALL_Y0[Y_W-1:0];
            dx_pos_reg      <= 1'b1;
            dy_pos_reg      <= 1'b1;
            pad_l_reg       <= PAD_Y0[Y_W-1:0];
            pad_r_reg       <= PAD_Y0[Y_W-1:0];
            score_l_reg     <= '0;
            score_r_reg     <= '0;
            left_scored_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            serve_cnt_reg   <= serve_cnt_next;
            ball_x_reg      <= ball_x_next;
            ball_y_reg      <= ball_y_next;
            dx_pos_reg      <= dx_pos_next;
            dy_pos_reg      <= dy_pos_next;
            pad_l_reg       <= pad_l_next;
            pad_r_reg       <= pad_r_next;
            score_l_reg     <= score_l_next;
            score_r_reg     <= score_r_next;
            left_scored_reg <= left_scored_next;
        end
    end

    assign xs       = $signed({1'b0, x});
    assign ys       = $signed({1'b0, y});
    assign pix_ball = (xs >= bx_s) && (xs < bx_s + BSZ_X) && (ys >= by_s) && (ys < by_s + BSZ_Y);
    assign pix_l    = (xs >= LPX) && (xs < LPX + PW_X) && (ys >= pl_s) && (ys < pl_s + PH_Y);
    assign pix_r    = (xs >= RPX) && (xs < RPX + PW_X) && (ys >= pr_s) && (ys < pr_s + PH_Y);
    assign pix_net  = (xs == NET_X) && !y[3] && (state_reg != ST_GAMEOVER);
    assign pixel_next = pix_ball || pix_l || pix_r || pix_net;

    // Registered object mask for the colour mux.
    always_ff @(posedge clk) begin
        if (!rst_n)
            pixel_reg <= 1'b0;
        else
            pixel_reg <= pixel_next;
    end

    assign pixel     = pixel_reg;
    assign score_l   = score_l_reg;
    assign score_r   = score_r_reg;
    assign game_over = (state_reg == ST_GAMEOVER);

endmodule

// File: tb/tb_pong_duel.sv
// tb_pong_duel: directed steps plus a randomized full game for pong_duel,
// checked against a frame-level behavioural model of the game rules.
// Build option PONG_AI_EN switches the model's right paddle to ball tracking.
module tb_pong_duel;

    localparam int SW = 640, SH = 480, BS = 8, PH = 48, PW = 8, PX = 16;
    localparam int PS = 4, BSP = 2, SF = 60, WIN = 7;
    localparam int RPX = SW - PX - PW;
    localparam int BX0 = (SW - BS) / 2, BY0 = (SH - BS) / 2, PY0 = (SH - PH) / 2;
    localparam int P_SERVE = 0, P_PLAY = 1, P_POINT = 2, P_OVER = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0, start = 1'b0;
    logic btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic pixel;
    logic [3:0] score_l, score_r;
    logic game_over;

    int tests = 0;
    int fails = 0;
    int n_ticks = 0;

    // Model state: ball position and velocity in px/frame, paddles, phase.
    int m_bx, m_by, m_vx, m_vy, m_pl, m_pr, m_phase, m_cnt, m_sl, m_sr;
    bit m_left_scored;

    pong_duel dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
        .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
        .x(x), .y(y), .pixel(pixel), .score_l(score_l), .score_r(score_r),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit exp_pixel(int px, int py);
        bit b, l, r, n;
        b = px >= m_bx && px < m_bx + BS && py >= m_by && py < m_by + BS;
        l = px >= PX && px < PX + PW && py >= m_pl && py < m_pl + PH;
        r = px >= RPX && px < RPX + PW && py >= m_pr && py < m_pr + PH;
        n = px == SW / 2 && (py % 16) < 8 && m_phase != P_OVER;
        return b || l || r || n;
    endfunction

    task automatic model_reset();
        m_bx = BX0; m_by = BY0; m_vx = BSP; m_vy = BSP;
        m_pl = PY0; m_pr = PY0; m_phase = P_SERVE; m_cnt = 0;
        m_sl = 0; m_sr = 0; m_left_scored = 0;
    endtask

    task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
        int pl0, pr0, nx, ny, rmove;
`ifdef PONG_AI_EN
        int err;
`endif
        pl0 = m_pl;
        pr0 = m_pr;
        if (m_phase == P_OVER) begin
            if (st) model_reset();
            return;
        end
        m_pl = clampi(m_pl + PS * (int'(ld) - int'(lu)), 0, SH - PH);
`ifdef PONG_AI_EN
        err = (m_by + BS / 2) - (pr0 + PH / 2);
        rmove = (err >= PS) ? PS : ((err <= -PS) ? -PS : 0);
`else
        rmove = PS * (int'(rd) - int'(ru));
`endif
        m_pr = clampi(m_pr + rmove, 0, SH - PH);
        case (m_phase)
            P_SERVE: begin
                if (m_cnt == SF - 1) begin m_phase = P_PLAY; m_cnt = 0; end
                else m_cnt++;
            end
            P_PLAY: begin
                nx = m_bx + m_vx;
                ny = m_by + m_vy;
                if (ny <= 0) begin ny = 0; m_vy = BSP; end
                else if (ny >= SH - BS) begin ny = SH - BS; m_vy = -BSP; end
                if (m_vx < 0 && nx <= PX + PW && nx + BS > PX && ny + BS > pl0 && ny < pl0 + PH) begin
                    nx = PX + PW; m_vx = BSP;
                end else if (m_vx > 0 && nx + BS >= RPX && nx < RPX + PW && ny + BS > pr0 && ny < pr0 + PH) begin
                    nx = RPX - BS; m_vx = -BSP;
                end
                m_bx = nx;
                m_by = ny;
                if (nx <= 0) begin m_phase = P_POINT; m_left_scored = 0; end
                else if (nx >= SW - BS) begin m_phase = P_POINT; m_left_scored = 1; end
            end
            P_POINT: begin
                if (m_left_scored) m_sl++; else m_sr++;
                if (m_sl == WIN || m_sr == WIN) begin
                    m_phase = P_OVER;
                end else begin
                    m_phase = P_SERVE; m_cnt = 0;
                    m_bx = BX0; m_by = BY0; m_vy = BSP;
                    m_vx = m_left_scored ? BSP : -BSP;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ball_x"}, 32'(dut.ball_x_reg), 32'(m_bx));
        check({tag, "_ball_y"}, 32'(dut.ball_y_reg), 32'(m_by));
        check({tag, "_pad_l"}, 32'(dut.pad_l_reg), 32'(m_pl));
        check({tag, "_pad_r"}, 32'(dut.pad_r_reg), 32'(m_pr));
        check({tag, "_score_l"}, 32'(score_l), 32'(m_sl));
        check({tag, "_score_r"}, 32'(score_r), 32'(m_sr));
        check({tag, "_game_over"}, 32'(game_over), 32'(m_phase == P_OVER));
    endtask

    task automatic probe(input int px, input int py);
        x = px[9:0];
        y = py[8:0];
        @(posedge clk); #1;
        check("pixel", 32'(pixel), 32'(exp_pixel(px, py)));
    endtask

    task automatic do_tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
        btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd; start = st;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        start = 1'b0;
        model_tick(lu, ld, ru, rd, st);
        n_ticks++;
        check_state("tick");
        $display("[TB] tick %0d phase %0d ball (%0d,%0d) pad %0d/%0d score %0d-%0d",
                 n_ticks, m_phase, m_bx, m_by, m_pl, m_pr, m_sl, m_sr);
    endtask

    task automatic random_tick_with_probes();
        int r, sel;
        r = int'($urandom_range(0, 15));
        do_tick(r[0], r[1], r[2], r[3], 1'b0);
        probe(clampi(m_bx - 2 + int'($urandom_range(0, 11)), 0, SW - 1),
              clampi(m_by - 2 + int'($urandom_range(0, 11)), 0, SH - 1));
        sel = int'($urandom_range(0, 2));
        if (sel == 0)
            probe(PX - 1 + int'($urandom_range(0, 9)), clampi(m_pl - 2 + int'($urandom_range(0, 51)), 0, SH - 1));
        else if (sel == 1)
            probe(RPX - 1 + int'($urandom_range(0, 9)), clampi(m_pr - 2 + int'($urandom_range(0, 51)), 0, SH - 1));
        else
            probe(SW / 2 - 1 + int'($urandom_range(0, 2)), int'($urandom_range(0, SH - 1)));
    endtask

    initial begin
        int guard;
        // Reset with a coincident frame tick: reset must win, pixel must be 0.
        rst_n = 1'b0; x = 10'd320; y = 9'd240; frame_tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frame_tick = 1'b0;
        model_reset();
        check("reset_pixel", 32'(pixel), 32'd0);
        check_state("reset");
        rst_n = 1'b1;
        probe(320, 240);
        probe(320, 0);
        probe(320, 8);

        // Serve hold, then launch.
        repeat (SF) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("serve_still_centre_x", 32'(dut.ball_x_reg), 32'd316);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("launch_x", 32'(dut.ball_x_reg), 32'd318);
        check("launch_y", 32'(dut.ball_y_reg), 32'd238);
        probe(320, 240);

        // Left paddle driven to the top clamp, then both buttons hold it.
        repeat (60) do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pad_l_top", 32'(dut.pad_l_reg), 32'd0);
        repeat (3) do_tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pad_l_both_hold", 32'(dut.pad_l_reg), 32'd0);

        // Randomized play until someone wins, bounded.
        guard = 0;
        while (m_phase != P_OVER && guard < 12000) begin
            random_tick_with_probes();
            guard++;
        end
        check("reached_game_over", 32'(game_over), 32'd1);
        check("winner_at_win_score", 32'(score_l == 4'(WIN) || score_r == 4'(WIN)), 32'd1);

        // Frozen in game over; start without a tick does nothing.
        do_tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        probe(320, 0);
        start = 1'b1;
        probe(320, 16);
        start = 1'b0;
        check("over_holds_without_tick", 32'(game_over), 32'd1);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("restart_score_l", 32'(score_l), 32'd0);
        check("restart_score_r", 32'(score_r), 32'd0);
        probe(320, 0);

        // Play a while, then reset mid-game.
        repeat (100) random_tick_with_probes();
        rst_n = 1'b0; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        model_reset();
        check("midgame_reset_pixel", 32'(pixel), 32'd0);
        check_state("midgame_reset");
        rst_n = 1'b1;
        probe(320, 240);
        repeat (70) random_tick_with_probes();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
